// File: rtl/mem_stall_ctrl.sv
// mem_stall_ctrl: stalls the pipeline while a MEM-stage load or store goes
// to a slow backing memory over a req/ack handshake.
//
// Build option: define MEM_STALL_CTRL_LINE_BUF_EN to add a one-entry word
// buffer that answers read hits in IDLE with no stall (write-through on
// matching stores).
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | no transfer; a miss latches the access and stalls this cycle
// REQ   | request held on the memory port until mem_ack_i
// DONE  | one unstalled cycle so the frozen pipeline consumes the result
module mem_stall_ctrl (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic [31:0] Addr_i,
    input  logic [31:0] WriteData_i,
    output logic [31:0] ReadData_o,
    output logic        MemStall_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_we;
    logic [31:0] r_rdata;

    logic        w_access;
    logic        w_hit;
    logic        w_start;
    logic        w_ack;
    logic        w_buf_rd;
    logic [31:0] w_buf_data;
    logic [31:0] w_addr_aligned;

    // Byte offset is dropped here: the memory is word-addressed and
    // misaligned accesses are silently rounded down.
    assign w_access       = MemRead_i | MemWrite_i;
    assign w_addr_aligned = {Addr_i[31:2], 2'b00};
    assign w_ack          = (r_state == ST_REQ) & mem_ack_i;
    assign w_buf_rd       = (r_state == ST_IDLE) & w_hit;

`ifdef MEM_STALL_CTRL_LINE_BUF_EN
    logic        r_buf_valid;
    logic [29:0] r_buf_tag;
    logic [31:0] r_buf_data;

    // A combined read+write is a store, so only a pure read can hit.
    assign w_hit      = r_buf_valid & MemRead_i & ~MemWrite_i &
                        (r_buf_tag == w_addr_aligned[31:2]);
    assign w_buf_data = r_buf_data;

    // Buffer fill on read completion, write-through on a matching store.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_buf_valid <= 1'b0;
            r_buf_tag   <= '0;
            r_buf_data  <= '0;
        end else if (w_ack) begin
            if (!r_we) begin
                r_buf_valid <= 1'b1;
                r_buf_tag   <= r_addr[31:2];
                r_buf_data  <= mem_rdata_i;
            end else if (r_buf_valid && (r_buf_tag == r_addr[31:2])) begin
                r_buf_data  <= r_wdata;
            end
        end
    end
`else
    assign w_hit      = 1'b0;
    assign w_buf_data = '0;
`endif

    // State register.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and stall decode; stall is raised in the IDLE miss cycle
    // itself so the pipeline freezes before the access slips past.
    always_comb begin
        w_state_nxt = r_state;
        MemStall_o  = 1'b0;
        w_start     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_access && !w_hit) begin
                    w_start     = 1'b1;
                    MemStall_o  = 1'b1;
                    w_state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                MemStall_o = 1'b1;
                if (mem_ack_i) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        if (!rst_i) begin
            MemStall_o = 1'b0;
        end
    end

    // Request latch and load-data register.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_we    <= 1'b0;
            r_rdata <= '0;
        end else begin
            if (w_start) begin
                r_addr  <= w_addr_aligned;
                r_wdata <= WriteData_i;
                r_we    <= MemWrite_i;
            end
            if (w_ack && !r_we) begin
                r_rdata <= mem_rdata_i;
            end else if (w_buf_rd) begin
                r_rdata <= w_buf_data;
            end
        end
    end

    assign mem_req_o   = (r_state == ST_REQ);
    assign mem_we_o    = r_we;
    assign mem_addr_o  = r_addr;
    assign mem_wdata_o = r_wdata;
    assign ReadData_o  = r_rdata;

endmodule

// File: tb/tb_mem_stall_ctrl.sv
// Directed bench for mem_stall_ctrl; follows the build macro
// MEM_STALL_CTRL_LINE_BUF_EN for the buffer-dependent expectations.
module tb_mem_stall_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        MemRead_i;
    logic        MemWrite_i;
    logic [31:0] Addr_i;
    logic [31:0] WriteData_i;
    logic [31:0] ReadData_o;
    logic        MemStall_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;

    int errors = 0;
    int checks = 0;

    mem_stall_ctrl dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .MemRead_i   (MemRead_i),
        .MemWrite_i  (MemWrite_i),
        .Addr_i      (Addr_i),
        .WriteData_i (WriteData_i),
        .ReadData_o  (ReadData_o),
        .MemStall_o  (MemStall_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_ack_i   (mem_ack_i),
        .mem_rdata_i (mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    // Missed access: IDLE cycle, k+1 REQ cycles with ack in the last, DONE.
    task automatic access(input string tag, input logic rd, input logic wr,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_addr, input logic [31:0] rdata,
                          input int k, input logic [31:0] rd_exp);
        int stalls;
        stalls      = 0;
        MemRead_i   = rd;
        MemWrite_i  = wr;
        Addr_i      = addr;
        WriteData_i = wdata;
        for (int c = 0; c <= k + 2; c++) begin
            mem_ack_i   = (c == k + 1);
            mem_rdata_i = (c == k + 1) ? rdata : 32'h0BAD_0BAD;
            @(negedge clk_i);
            if (MemStall_o === 1'b1) stalls++;
            if (c == 0) chk({tag, "_idle_req"}, {31'd0, mem_req_o}, 32'd0);
            if (c >= 1 && c <= k + 1) chk({tag, "_req_held"}, {31'd0, mem_req_o}, 32'd1);
            if (c == k + 1) begin
                chk({tag, "_addr"}, mem_addr_o, exp_addr);
                chk({tag, "_we"}, {31'd0, mem_we_o}, {31'd0, wr});
                if (wr) chk({tag, "_wdata"}, mem_wdata_o, wdata);
            end
            if (c == k + 2) begin
                chk({tag, "_done_req"}, {31'd0, mem_req_o}, 32'd0);
                chk({tag, "_done_stall"}, {31'd0, MemStall_o}, 32'd0);
                chk({tag, "_done_rdata"}, ReadData_o, rd_exp);
            end
            next_cycle();
        end
        MemRead_i  = 1'b0;
        MemWrite_i = 1'b0;
        mem_ack_i  = 1'b0;
        chk({tag, "_stall_cycles"}, stalls, k + 2);
        @(negedge clk_i);
        chk({tag, "_after_req"}, {31'd0, mem_req_o}, 32'd0);
        chk({tag, "_after_stall"}, {31'd0, MemStall_o}, 32'd0);
        chk({tag, "_after_rdata"}, ReadData_o, rd_exp);
        next_cycle();
    endtask

    // Read expected to hit the line buffer: no stall, data at next edge.
    task automatic buf_hit(input string tag, input logic [31:0] addr, input logic [31:0] rd_exp);
        MemRead_i  = 1'b1;
        MemWrite_i = 1'b0;
        Addr_i     = addr;
        @(negedge clk_i);
        chk({tag, "_stall"}, {31'd0, MemStall_o}, 32'd0);
        chk({tag, "_req"}, {31'd0, mem_req_o}, 32'd0);
        next_cycle();
        MemRead_i = 1'b0;
        @(negedge clk_i);
        chk({tag, "_rdata"}, ReadData_o, rd_exp);
        chk({tag, "_still_idle"}, {31'd0, mem_req_o}, 32'd0);
        next_cycle();
    endtask

    initial begin
        rst_i       = 1'b0;
        MemRead_i   = 1'b1;
        MemWrite_i  = 1'b0;
        Addr_i      = 32'h0000_0100;
        WriteData_i = 32'h0;
        mem_ack_i   = 1'b0;
        mem_rdata_i = 32'h0;

        // Reset: stall forced low even with an access pending.
        @(negedge clk_i);
        chk("rst_stall", {31'd0, MemStall_o}, 32'd0);
        next_cycle();
        MemRead_i = 1'b0;
        @(negedge clk_i);
        chk("rst_rdata", ReadData_o, 32'h0);
        chk("rst_req", {31'd0, mem_req_o}, 32'd0);
        chk("rst_we", {31'd0, mem_we_o}, 32'd0);
        chk("rst_addr", mem_addr_o, 32'h0);
        chk("rst_wdata", mem_wdata_o, 32'h0);
        next_cycle();
        rst_i = 1'b1;
        next_cycle();

        // Read, ack 3 cycles into REQ: 5 stall cycles.
        access("rd100", 1'b1, 1'b0, 32'h0000_0100, 32'h0, 32'h0000_0100,
               32'hDEAD_BEEF, 3, 32'hDEAD_BEEF);

        // Write with immediate ack: 2 stall cycles, load data untouched.
        access("wr204", 1'b0, 1'b1, 32'h0000_0204, 32'h1234_5678, 32'h0000_0204,
               32'h0BAD_0BAD, 0, 32'hDEAD_BEEF);

        // Stray ack in IDLE is ignored.
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'hFFFF_0000;
        @(negedge clk_i);
        chk("stray_stall", {31'd0, MemStall_o}, 32'd0);
        chk("stray_req", {31'd0, mem_req_o}, 32'd0);
        next_cycle();
        mem_ack_i = 1'b0;
        @(negedge clk_i);
        chk("stray_rdata", ReadData_o, 32'hDEAD_BEEF);
        next_cycle();

        // Read+write together performs only the write.
        access("rdwr8", 1'b1, 1'b1, 32'h0000_0008, 32'hCAFE_F00D, 32'h0000_0008,
               32'h0BAD_0BAD, 1, 32'hDEAD_BEEF);

        // Misaligned byte address is rounded down to the word.
        access("rd10b", 1'b1, 1'b0, 32'h0000_010B, 32'h0, 32'h0000_0108,
               32'h55AA_33CC, 0, 32'h55AA_33CC);

        // Reset in the 2nd REQ cycle, late ack afterwards is ignored.
        MemRead_i = 1'b1;
        Addr_i    = 32'h0000_0300;
        @(negedge clk_i);
        chk("rstreq_idle_stall", {31'd0, MemStall_o}, 32'd1);
        next_cycle();
        @(negedge clk_i);
        chk("rstreq_req1", {31'd0, mem_req_o}, 32'd1);
        next_cycle();
        rst_i = 1'b0;
        @(negedge clk_i);
        chk("rstreq_stall_in_rst", {31'd0, MemStall_o}, 32'd0);
        next_cycle();
        rst_i       = 1'b1;
        MemRead_i   = 1'b0;
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'h7777_7777;
        @(negedge clk_i);
        chk("rstreq_req_dropped", {31'd0, mem_req_o}, 32'd0);
        chk("rstreq_stall", {31'd0, MemStall_o}, 32'd0);
        chk("rstreq_rdata", ReadData_o, 32'h0);
        next_cycle();
        mem_ack_i = 1'b0;
        @(negedge clk_i);
        chk("rstreq_rdata_late", ReadData_o, 32'h0);
        chk("rstreq_addr", mem_addr_o, 32'h0);
        next_cycle();

        // Line-buffer sequence.
        access("lb_rd40", 1'b1, 1'b0, 32'h0000_0040, 32'h0, 32'h0000_0040,
               32'hA5A5_A5A5, 1, 32'hA5A5_A5A5);
`ifdef MEM_STALL_CTRL_LINE_BUF_EN
        buf_hit("lb_rd42", 32'h0000_0042, 32'hA5A5_A5A5);
`else
        access("lb_rd42", 1'b1, 1'b0, 32'h0000_0042, 32'h0, 32'h0000_0040,
               32'hA5A5_A5A5, 0, 32'hA5A5_A5A5);
`endif
        access("lb_wr40", 1'b0, 1'b1, 32'h0000_0040, 32'h0000_0001, 32'h0000_0040,
               32'h0BAD_0BAD, 0, 32'hA5A5_A5A5);
`ifdef MEM_STALL_CTRL_LINE_BUF_EN
        buf_hit("lb_rd40b", 32'h0000_0040, 32'h0000_0001);
`else
        access("lb_rd40b", 1'b1, 1'b0, 32'h0000_0040, 32'h0, 32'h0000_0040,
               32'h0000_0001, 0, 32'h0000_0001);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
